subservient_boot_ctrl: RTL and testbench

SUBSERVIENT_BOOT_CTRL -- requirements
Module: subservient_boot_ctrl

---
 rtl/subservient_pkg.sv | 13 +
 rtl/subservient_boot_ctrl_if.sv | 14 +
 rtl/subservient_boot_ctrl.sv | 107 ++++++++++
 tb/tb_subservient_boot_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/subservient_pkg.sv
// rtl/subservient_pkg.sv - shared boot controller state encodings and default load window
package subservient_pkg;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        SETTLE = 2'd1,
        RUN    = 2'd2
    } boot_state_t;

    localparam int DEF_BOOT_BASE  = 0;
    localparam int DEF_BOOT_BYTES = 256;

endpackage

// File: rtl/subservient_boot_ctrl_if.sv
// rtl/subservient_boot_ctrl_if.sv - byte-wide SRAM port bundle (core side or physical side)
interface subservient_boot_ctrl_if #(
    parameter int aw = 9
);
    logic [aw-1:0] waddr;
    logic [7:0]    wdata;
    logic          wen;
    logic [aw-1:0] raddr;
    logic          ren;
    logic [7:0]    rdata;

    modport master (output waddr, wdata, wen, raddr, ren, input rdata);
    modport slave  (input waddr, wdata, wen, raddr, ren, output rdata);
endinterface

// File: rtl/subservient_boot_ctrl.sv
// rtl/subservient_boot_ctrl.sv - streams a boot image into SRAM, then hands the SRAM port to the core
module subservient_boot_ctrl
    import subservient_pkg::*;
#(
    parameter int memsize    = 512,
    parameter int aw         = $clog2(memsize),
    parameter int BOOT_BASE  = DEF_BOOT_BASE,
    parameter int BOOT_BYTES = DEF_BOOT_BYTES
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_boot_req,
    input  logic [7:0]    i_data,
    input  logic          i_valid,
    output logic          o_ready,
    output logic          o_core_rst,
    output logic          o_done,
    output logic [7:0]    o_csum,
    input  logic [aw-1:0] i_core_waddr,
    input  logic [7:0]    i_core_wdata,
    input  logic          i_core_wen,
    input  logic [aw-1:0] i_core_raddr,
    input  logic          i_core_ren,
    output logic [7:0]    o_core_rdata,
    output logic [aw-1:0] o_sram_waddr,
    output logic [7:0]    o_sram_wdata,
    output logic          o_sram_wen,
    output logic [aw-1:0] o_sram_raddr,
    input  logic [7:0]    i_sram_rdata,
    output logic          o_sram_ren
);

    localparam int cw = $clog2(BOOT_BYTES + 1);

    boot_state_t   state, state_nxt;
    logic [cw-1:0] cnt, cnt_nxt;
    logic [7:0]    csum, csum_nxt;
    logic          core_rst;
    logic          accept;

    // A restart request blocks acceptance so the restarting cycle cannot land a byte.
    assign o_ready = (state == LOAD) && !i_boot_req;
    assign accept  = i_valid && o_ready;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        csum_nxt  = csum;
        case (state)
            LOAD: begin
                if (i_boot_req) begin
                    cnt_nxt  = '0;
                    csum_nxt = '0;
                end else if (accept) begin
                    cnt_nxt  = cnt + 1'b1;
                    csum_nxt = csum + i_data;
                    if (cnt == cw'(BOOT_BYTES - 1)) state_nxt = SETTLE;
                end
            end
            SETTLE: state_nxt = RUN;
            RUN: begin
                if (i_boot_req) begin
                    state_nxt = LOAD;
                    cnt_nxt   = '0;
                    csum_nxt  = '0;
                end
            end
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= LOAD;
            cnt      <= '0;
            csum     <= '0;
            core_rst <= 1'b1;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            csum     <= csum_nxt;
            core_rst <= (state_nxt != RUN);
        end
    end

    assign o_core_rst   = core_rst;
    assign o_done       = (state == RUN);
    assign o_csum       = csum;
    assign o_core_rdata = i_sram_rdata;

    // The core owns the SRAM only while running; otherwise the loader drives writes and reads are parked.
    always_comb begin
        o_sram_waddr = aw'(BOOT_BASE) + aw'(cnt);
        o_sram_wdata = i_data;
        o_sram_wen   = accept;
        o_sram_raddr = '0;
        o_sram_ren   = 1'b0;
        if (state == RUN) begin
            o_sram_waddr = i_core_waddr;
            o_sram_wdata = i_core_wdata;
            o_sram_wen   = i_core_wen;
            o_sram_raddr = i_core_raddr;
            o_sram_ren   = i_core_ren;
        end
    end

endmodule

// File: tb/tb_subservient_boot_ctrl.sv
// tb/tb_subservient_boot_ctrl.sv - self-checking bench for the boot loader controller
module tb_subservient_boot_ctrl;

    localparam int MEMSIZE = 512;
    localparam int AW      = 9;
    localparam int BASE    = 'h10;
    localparam int NBYTES  = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       boot_req;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       core_rst;
    logic       done;
    logic [7:0] csum;

    subservient_boot_ctrl_if #(.aw(AW)) core_bus ();
    subservient_boot_ctrl_if #(.aw(AW)) sram_bus ();

    subservient_boot_ctrl #(
        .memsize(MEMSIZE), .aw(AW), .BOOT_BASE(BASE), .BOOT_BYTES(NBYTES)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_boot_req(boot_req), .i_data(data),
        .i_valid(valid), .o_ready(ready), .o_core_rst(core_rst), .o_done(done),
        .o_csum(csum),
        .i_core_waddr(core_bus.waddr), .i_core_wdata(core_bus.wdata),
        .i_core_wen(core_bus.wen), .i_core_raddr(core_bus.raddr),
        .i_core_ren(core_bus.ren), .o_core_rdata(core_bus.rdata),
        .o_sram_waddr(sram_bus.waddr), .o_sram_wdata(sram_bus.wdata),
        .o_sram_wen(sram_bus.wen), .o_sram_raddr(sram_bus.raddr),
        .i_sram_rdata(sram_bus.rdata), .o_sram_ren(sram_bus.ren)
    );

    always #5 clk = ~clk;

    // Physical SRAM: synchronous write, registered read.
    logic [7:0] mem [MEMSIZE];
    always @(posedge clk) begin
        if (sram_bus.wen) mem[sram_bus.waddr] <= sram_bus.wdata;
        if (sram_bus.ren) sram_bus.rdata <= mem[sram_bus.raddr];
    end

    // Reference model: expected memory image, bytes taken in the current load, running sum.
    logic [7:0] exp_mem [MEMSIZE];
    bit         exp_known [MEMSIZE];
    int         exp_cnt;
    logic [7:0] exp_csum;
    logic [7:0] src [NBYTES];
    int         total = 0;
    int         bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_mem(input string tag);
        int miss = 0;
        for (int a = 0; a < MEMSIZE; a++)
            if (exp_known[a] && mem[a] !== exp_mem[a]) miss++;
        chk(tag, miss, 0);
    endtask

    task automatic random_src();
        for (int i = 0; i < NBYTES; i++) src[i] = 8'($urandom_range(0, 255));
    endtask

    // Streams src[0..n-1]; when that completes the image, also walks SETTLE into RUN.
    task automatic load(input int n, input bit gap, input bit req_in_settle);
        for (int i = 0; i < n; i++) begin
            if (gap || ($urandom_range(0, 3) == 0 && i > 0 && gap)) begin
                valid = 1'b0;
                data  = 8'($urandom_range(0, 255));
                #1;
                chk("gap_wen", sram_bus.wen, 0);
                tick();
            end
            valid = 1'b1;
            data  = src[i];
            #1;
            chk("ld_ready", ready, 1);
            chk("ld_wen", sram_bus.wen, 1);
            chk("ld_waddr", sram_bus.waddr, BASE + exp_cnt);
            chk("ld_wdata", sram_bus.wdata, src[i]);
            exp_mem[BASE + exp_cnt]   = src[i];
            exp_known[BASE + exp_cnt] = 1'b1;
            exp_cnt++;
            exp_csum = exp_csum + src[i];
            tick();
        end
        valid = 1'b0;
        if (exp_cnt == NBYTES) begin
            valid    = 1'b1;
            boot_req = req_in_settle;
            #1;
            chk("settle_rst", core_rst, 1);
            chk("settle_done", done, 0);
            chk("settle_ready", ready, 0);
            chk("settle_wen", sram_bus.wen, 0);
            chk("settle_csum", csum, exp_csum);
            tick();
            valid    = 1'b0;
            boot_req = 1'b0;
            #1;
            chk("run_rst", core_rst, 0);
            chk("run_done", done, 1);
            chk("run_csum", csum, exp_csum);
            exp_cnt = 0;
        end
    endtask

    task automatic core_idle();
        core_bus.waddr = '0;
        core_bus.wdata = '0;
        core_bus.wen   = 1'b0;
        core_bus.raddr = '0;
        core_bus.ren   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; boot_req = 1'b0; valid = 1'b0; data = '0;
        core_idle();
        exp_cnt = 0; exp_csum = '0;
        for (int a = 0; a < MEMSIZE; a++) begin exp_known[a] = 1'b0; exp_mem[a] = '0; end

        #2;
        chk("reset_core_rst", core_rst, 1);
        chk("reset_done", done, 0);
        chk("reset_csum", csum, 0);
        chk("reset_ready", ready, 1);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Fixed image 01..04: sum 0x0A, core released once through SETTLE.
        for (int i = 0; i < NBYTES; i++) src[i] = 8'(i + 1);
        load(NBYTES, 1'b0, 1'b0);
        chk("fixed_csum", csum, 'h0A);
        check_mem("fixed_mem");

        // Valid pulses in RUN must not reach the loader.
        valid = 1'b1; data = 8'hFF;
        #1;
        chk("run_valid_wen", sram_bus.wen, 0);
        tick();
        valid = 1'b0;
        chk("run_valid_csum", csum, exp_csum);

        // Core write then read through the mux.
        core_bus.waddr = 9'h1FF; core_bus.wdata = 8'hA5; core_bus.wen = 1'b1;
        #1;
        chk("core_waddr", sram_bus.waddr, 'h1FF);
        chk("core_wdata", sram_bus.wdata, 'hA5);
        chk("core_wen", sram_bus.wen, 1);
        exp_mem['h1FF] = 8'hA5; exp_known['h1FF] = 1'b1;
        tick();
        core_idle();
        core_bus.raddr = 9'h1FF; core_bus.ren = 1'b1;
        #1;
        chk("core_raddr", sram_bus.raddr, 'h1FF);
        chk("core_ren", sram_bus.ren, 1);
        tick();
        core_idle();
        chk("core_rdata", core_bus.rdata, 'hA5);

        // Restart from RUN: core port is cut off immediately.
        boot_req = 1'b1;
        tick();
        boot_req = 1'b0;
        exp_csum = '0; exp_cnt = 0;
        chk("reboot_rst", core_rst, 1);
        chk("reboot_done", done, 0);
        chk("reboot_csum", csum, 0);
        core_bus.waddr = 9'h1FF; core_bus.wdata = 8'h5A; core_bus.wen = 1'b1;
        #1;
        chk("cutoff_wen", sram_bus.wen, 0);
        tick();
        core_idle();
        check_mem("cutoff_mem");

        // Fresh gapped random load.
        random_src();
        load(NBYTES, 1'b1, 1'b0);
        check_mem("gapped_mem");

        // Restart mid-load: the colliding byte is dropped, reload starts at base; request in SETTLE is ignored.
        boot_req = 1'b1;
        tick();
        boot_req = 1'b0;
        exp_csum = '0; exp_cnt = 0;
        random_src();
        load(2, 1'b0, 1'b0);
        boot_req = 1'b1; valid = 1'b1; data = 8'hEE;
        #1;
        chk("restart_ready", ready, 0);
        chk("restart_wen", sram_bus.wen, 0);
        tick();
        boot_req = 1'b0; valid = 1'b0;
        exp_csum = '0; exp_cnt = 0;
        chk("restart_csum", csum, 0);
        random_src();
        load(NBYTES, 1'b0, 1'b1);
        check_mem("restart_mem");

        // Asynchronous reset mid-run.
        #3 rst = 1'b1;
        #1;
        chk("arst_run_rst", core_rst, 1);
        chk("arst_run_done", done, 0);
        chk("arst_run_csum", csum, 0);
        tick();
        rst = 1'b0;
        exp_csum = '0; exp_cnt = 0;
        tick();

        // Asynchronous reset mid-load: written bytes survive, next load overwrites from base.
        random_src();
        load(2, 1'b0, 1'b0);
        #3 rst = 1'b1;
        #1;
        chk("arst_load_rst", core_rst, 1);
        chk("arst_load_csum", csum, 0);
        chk("arst_load_done", done, 0);
        tick();
        rst = 1'b0;
        exp_csum = '0; exp_cnt = 0;
        check_mem("arst_keep_mem");
        tick();
        random_src();
        load(NBYTES, 1'b1, 1'b0);
        check_mem("final_mem");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule
